// File: rtl/data_mem_banked_if.sv
// Request/response bundle between the MEM stage and the banked data memory.
// The master side issues accesses; the slave side is the memory.
interface data_mem_banked_if #(
    parameter int unsigned DATA_W = 32
);
    logic [31:0]       adr;
    logic [DATA_W-1:0] data_in;
    logic              MEM_R_EN;
    logic              MEM_W_EN;
    logic [1:0]        size;
    logic              sign_ext;
    logic [DATA_W-1:0] DATA;
    logic              busy;
    logic              ready;
    logic              err;

    modport master (
        output adr, data_in, MEM_R_EN, MEM_W_EN, size, sign_ext,
        input  DATA, busy, ready, err
    );

    modport slave (
        input  adr, data_in, MEM_R_EN, MEM_W_EN, size, sign_ext,
        output DATA, busy, ready, err
    );
endinterface

// File: rtl/data_mem_banked.sv
// Byte-addressed data RAM with byte/halfword/word access, configurable wait states,
// a busy/ready handshake and error pulses for misaligned or unmapped accesses.
module data_mem_banked #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH_BYTES = 512,
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned BIG_ENDIAN  = 1
) (
    input logic              clk,
    input logic              rst,
    data_mem_banked_if.slave bus
);
    localparam int unsigned NB  = DATA_W / 8;
    localparam int unsigned AW  = $clog2(DEPTH_BYTES);
    localparam int unsigned LSB = $clog2(NB);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e            r_state, w_state_d;
    logic [3:0]        r_cnt, w_cnt_d;
    logic [31:0]       r_adr;
    logic [DATA_W-1:0] r_wdata;
    logic [1:0]        r_size;
    logic              r_sext;
    logic              r_is_read;
    logic [DATA_W-1:0] r_data, w_data_d;
    logic              r_busy, w_busy_d;
    logic              r_ready, w_ready_d;
    logic              r_err, w_err_d;
    logic              w_accept;
    logic              w_commit;
    logic [7:0]        r_mem [DEPTH_BYTES];

    logic [31:0]       w_offset;
    logic [32:0]       w_nbytes;
    logic [32:0]       w_end;
    logic [AW-1:0]     w_idx;
    logic              w_fault;
    logic [7:0]        w_rd_b;
    logic [7:0]        w_rd_b1;
    logic [15:0]       w_rd_h;
    logic [DATA_W-1:0] w_rd_word;
    logic [DATA_W-1:0] w_rd_data;

    // Fault decode works on the latched request so it is stable through WAIT.
    assign w_offset = r_adr - 32'(BASE_ADDR);
    assign w_idx    = w_offset[AW-1:0];

    always_comb begin
        case (r_size)
            2'b00:   w_nbytes = 33'd1;
            2'b01:   w_nbytes = 33'd2;
            2'b10:   w_nbytes = 33'(NB);
            default: w_nbytes = 33'd0;
        endcase
    end

    // 33-bit sum so addresses below the base wrap to a huge offset and fault.
    assign w_end   = {1'b0, w_offset} + w_nbytes;
    assign w_fault = (r_size == 2'b11)
                  || (w_end > 33'(DEPTH_BYTES))
                  || ((r_size == 2'b01) && w_offset[0])
                  || ((r_size == 2'b10) && (w_offset[LSB-1:0] != '0));

    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < int'(NB); i++) begin
            if (BIG_ENDIAN != 0) begin
                w_rd_word[8*(int'(NB)-1-i) +: 8] = r_mem[w_idx + AW'(i)];
            end else begin
                w_rd_word[8*i +: 8] = r_mem[w_idx + AW'(i)];
            end
        end
        w_rd_b  = r_mem[w_idx];
        w_rd_b1 = r_mem[w_idx + AW'(1)];
        w_rd_h  = (BIG_ENDIAN != 0) ? {w_rd_b, w_rd_b1} : {w_rd_b1, w_rd_b};
        case (r_size)
            2'b00: begin
                w_rd_data       = {DATA_W{r_sext & w_rd_b[7]}};
                w_rd_data[7:0]  = w_rd_b;
            end
            2'b01: begin
                w_rd_data       = {DATA_W{r_sext & w_rd_h[15]}};
                w_rd_data[15:0] = w_rd_h;
            end
            default: w_rd_data = w_rd_word;
        endcase
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_busy_d  = r_busy;
        w_ready_d = 1'b0;
        w_err_d   = 1'b0;
        w_data_d  = r_data;
        w_accept  = 1'b0;
        w_commit  = 1'b0;
        case (r_state)
            StIdle: begin
                if (bus.MEM_R_EN || bus.MEM_W_EN) begin
                    w_accept = 1'b1;
                    w_busy_d = 1'b1;
                    if (WAIT_STATES != 0) begin
                        w_state_d = StWait;
                        w_cnt_d   = 4'(WAIT_STATES - 1);
                    end else begin
                        w_state_d = StDone;
                    end
                end
            end
            StWait: begin
                if (r_cnt == 4'd0) begin
                    w_state_d = StDone;
                end else begin
                    w_cnt_d = r_cnt - 4'd1;
                end
            end
            StDone: begin
                w_state_d = StIdle;
                w_busy_d  = 1'b0;
                w_ready_d = 1'b1;
                w_err_d   = w_fault;
                if (!w_fault) begin
                    if (r_is_read) begin
                        w_data_d = w_rd_data;
                    end else begin
                        w_commit = 1'b1;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_busy  <= w_busy_d;
            r_ready <= w_ready_d;
            r_err   <= w_err_d;
            r_data  <= w_data_d;
        end
    end

    // Read wins when both enables are set; the write is silently dropped.
    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            r_adr     <= bus.adr;
            r_wdata   <= bus.data_in;
            r_size    <= bus.size;
            r_sext    <= bus.sign_ext;
            r_is_read <= bus.MEM_R_EN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_commit) begin
            case (r_size)
                2'b00: r_mem[w_idx] <= r_wdata[7:0];
                2'b01: begin
                    if (BIG_ENDIAN != 0) begin
                        r_mem[w_idx]          <= r_wdata[15:8];
                        r_mem[w_idx + AW'(1)] <= r_wdata[7:0];
                    end else begin
                        r_mem[w_idx]          <= r_wdata[7:0];
                        r_mem[w_idx + AW'(1)] <= r_wdata[15:8];
                    end
                end
                default: begin
                    for (int i = 0; i < int'(NB); i++) begin
                        if (BIG_ENDIAN != 0) begin
                            r_mem[w_idx + AW'(i)] <= r_wdata[8*(int'(NB)-1-i) +: 8];
                        end else begin
                            r_mem[w_idx + AW'(i)] <= r_wdata[8*i +: 8];
                        end
                    end
                end
            endcase
        end
    end

    assign bus.DATA  = r_data;
    assign bus.busy  = r_busy;
    assign bus.ready = r_ready;
    assign bus.err   = r_err;
endmodule

// File: tb/tb_data_mem_banked.sv
// Drives three memories (0, 2 and 3 wait states) with identical traffic and checks
// each against a byte-array model of the address map, endianness and fault rules.
module tb_data_mem_banked;
    localparam int NDUT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] t_adr;
    logic [31:0] t_din;
    logic        t_ren;
    logic        t_wen;
    logic [1:0]  t_size;
    logic        t_sext;

    logic [31:0] o_data  [NDUT];
    logic        o_busy  [NDUT];
    logic        o_ready [NDUT];
    logic        o_err   [NDUT];

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  mem_m [512];
    logic [31:0] exp_data;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        data_mem_banked_if #(.DATA_W(32)) bus ();
        assign bus.adr      = t_adr;
        assign bus.data_in  = t_din;
        assign bus.MEM_R_EN = t_ren;
        assign bus.MEM_W_EN = t_wen;
        assign bus.size     = t_size;
        assign bus.sign_ext = t_sext;
        assign o_data[g]    = bus.DATA;
        assign o_busy[g]    = bus.busy;
        assign o_ready[g]   = bus.ready;
        assign o_err[g]     = bus.err;

        data_mem_banked #(
            .DATA_W      (32),
            .DEPTH_BYTES (512),
            .BASE_ADDR   (1024),
            .WAIT_STATES ((g == 0) ? 0 : g + 1),
            .BIG_ENDIAN  (1)
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : k + 1;
    endfunction

    task automatic check(input string tag, input int k, input logic [31:0] obs,
                         input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s dut%0d: observed %h expected %h", tag, k, obs, expv);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        for (int k = 0; k < NDUT; k++) begin
            check({tag, "_data"}, k, o_data[k], 32'h0);
            check({tag, "_busy"}, k, 32'(o_busy[k]), 32'h0);
            check({tag, "_ready"}, k, 32'(o_ready[k]), 32'h0);
            check({tag, "_err"}, k, 32'(o_err[k]), 32'h0);
        end
    endtask

    // One access issued to all memories; the model decides fault and result from the rules.
    task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [1:0] sz, input bit sx,
                          input bit noise);
        logic [31:0] off;
        logic [31:0] newv;
        longint      v;
        int          n;
        int          w;
        bit          fault;
        off   = a - 32'd1024;
        n     = 1 << sz;
        fault = (sz == 2'd3) || (longint'(off) + longint'(n) > 512) || ((off % n) != 0);
        newv  = exp_data;
        if (!fault) begin
            if (rd) begin
                v = 0;
                for (int i = 0; i < n; i++) v = (v << 8) | longint'(mem_m[off + i]);
                if (sx && n < 4 && v[8*n-1]) v = v - (longint'(1) << (8 * n));
                newv = v[31:0];
            end else if (wr) begin
                for (int i = 0; i < n; i++) mem_m[off + i] = d[8*(n-1-i) +: 8];
            end
        end
        @(negedge clk);
        t_adr = a; t_din = d; t_ren = rd; t_wen = wr; t_size = sz; t_sext = sx;
        @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check("busy_start", k, 32'(o_busy[k]), 32'h1);
            check("ready_start", k, 32'(o_ready[k]), 32'h0);
        end
        if (noise) begin
            t_adr  = $urandom;
            t_din  = $urandom;
            t_size = 2'($urandom_range(0, 3));
            t_sext = 1'($urandom_range(0, 1));
            t_ren  = 1'b1;
            t_wen  = 1'b1;
        end else begin
            t_ren = 1'b0;
            t_wen = 1'b0;
        end
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                t_ren = 1'b0;
                t_wen = 1'b0;
            end
            for (int k = 0; k < NDUT; k++) begin
                w = ws_of(k);
                check("ready", k, 32'(o_ready[k]), 32'(c == w + 1));
                check("busy", k, 32'(o_busy[k]), 32'(c <= w));
                check("err", k, 32'(o_err[k]), 32'((c == w + 1) && fault));
                check("data", k, o_data[k], (c >= w + 1) ? newv : exp_data);
            end
        end
        exp_data = newv;
    endtask

    initial begin
        int          r;
        logic [31:0] a;
        logic [1:0]  sz;
        rst = 1'b1;
        t_adr = '0; t_din = '0; t_ren = 1'b0; t_wen = 1'b0; t_size = '0; t_sext = 1'b0;
        exp_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Give every RAM byte a known value.
        for (int i = 0; i < 128; i++) access(1'b0, 1'b1, 32'(1024 + 4 * i), $urandom, 2'd2, 1'b0, 1'b0);

        access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 2'd2, 1'b0, 1'b0);
        access(1'b1, 1'b0, 32'd1024, 32'h0, 2'd2, 1'b0, 1'b0);
        access(1'b1, 1'b0, 32'd1024, 32'h0, 2'd0, 1'b0, 1'b0);
        access(1'b1, 1'b0, 32'd1027, 32'h0, 2'd0, 1'b0, 1'b0);

        access(1'b0, 1'b1, 32'd1024, 32'h11223344, 2'd2, 1'b0, 1'b0);
        access(1'b0, 1'b1, 32'd1025, 32'h00000080, 2'd0, 1'b0, 1'b0);
        access(1'b1, 1'b0, 32'd1024, 32'h0, 2'd2, 1'b0, 1'b0);
        access(1'b1, 1'b0, 32'd1024, 32'h0, 2'd1, 1'b1, 1'b0);
        access(1'b1, 1'b0, 32'd1025, 32'h0, 2'd0, 1'b1, 1'b0);
        access(1'b1, 1'b0, 32'd1025, 32'h0, 2'd0, 1'b0, 1'b1);

        access(1'b1, 1'b0, 32'd1026, 32'h0, 2'd2, 1'b0, 1'b0);
        access(1'b0, 1'b1, 32'd1532, 32'hCAFEF00D, 2'd2, 1'b0, 1'b0);
        access(1'b0, 1'b1, 32'd1536, 32'h12345678, 2'd2, 1'b0, 1'b0);
        access(1'b1, 1'b0, 32'd1532, 32'h0, 2'd2, 1'b0, 1'b0);
        access(1'b1, 1'b0, 32'd1020, 32'h0, 2'd2, 1'b0, 1'b0);
        access(1'b1, 1'b0, 32'd1025, 32'h0, 2'd1, 1'b0, 1'b0);
        access(1'b1, 1'b0, 32'd1024, 32'h0, 2'd3, 1'b0, 1'b0);
        access(1'b1, 1'b0, 32'd1535, 32'h0, 2'd0, 1'b1, 1'b0);

        access(1'b1, 1'b1, 32'd1028, 32'h00000055, 2'd2, 1'b0, 1'b0);
        access(1'b1, 1'b0, 32'd1028, 32'h0, 2'd2, 1'b0, 1'b0);

        // Reset one cycle after a write request: nothing may be committed.
        @(negedge clk);
        t_adr = 32'd1032; t_din = 32'hA5A5A5A5; t_ren = 1'b0; t_wen = 1'b1;
        t_size = 2'd2; t_sext = 1'b0;
        @(posedge clk);
        #1;
        t_wen = 1'b0;
        rst   = 1'b1;
        @(posedge clk);
        #1;
        check_idle_zero("midreset");
        @(negedge clk);
        rst = 1'b0;
        exp_data = '0;
        access(1'b1, 1'b0, 32'd1032, 32'h0, 2'd2, 1'b0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            a  = 32'($urandom_range(1016, 1540));
            r  = int'($urandom_range(0, 9));
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            r  = int'($urandom_range(0, 2));
            access(r != 1, r != 0, a, $urandom, sz, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/data_mem_banked.md
Name: data_mem_banked

Overview:
- Parametrised successor to the single-cycle data memory of the pipelined core.
- Byte-addressed RAM mapped at a configurable base address.
- Supports byte, halfword and word accesses, with optional sign extension.
- Has a configurable number of wait states with a done/ready handshake, plus error flagging for misaligned or out-of-range accesses.
- Sits in the MEM stage; the hazard/freeze unit stalls the pipeline while `busy` is high.

Parameters:
- DATA_W, 32: data width in bits; must be a multiple of 8 and at least 16.
- DEPTH_BYTES, 512: RAM size in bytes; must be a power of two.
- BASE_ADDR, 1024: first mapped byte address.
- WAIT_STATES, 0: extra cycles per access; range 0..15.
- BIG_ENDIAN, 1: 1 means the lowest byte address holds the MS byte; 0 means little-endian.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- adr  in  32  byte address
- data_in  in  DATA_W  write data; the operand is right-aligned for byte and halfword accesses
- MEM_R_EN  in  1  read request
- MEM_W_EN  in  1  write request
- size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved (treated as err)
- sign_ext  in  1  sign-extend byte/halfword reads; 0 means zero-extend
- DATA  out  DATA_W  read result
- busy  out  1  access in progress
- ready  out  1  one-cycle pulse when an access completes
- err  out  1  one-cycle pulse together with `ready` on a faulted access

Behaviour:
- Reset values:
  - `DATA` = 0, `busy` = 0, `ready` = 0, `err` = 0, state = IDLE.
  - RAM contents are NOT cleared.
- States: IDLE, WAIT, DONE.
- IDLE:
  - Request = `MEM_R_EN` | `MEM_W_EN`, sampled on the rising edge.
  - If both are set, the read wins and the write is dropped (no error).
  - On a request, latch `adr`, `data_in`, `size`, `sign_ext` and op. Set `busy` = 1.
  - Next state: WAIT if WAIT_STATES > 0, otherwise DONE.
- WAIT:
  - A counter loads WAIT_STATES-1 on entry and decrements each cycle.
  - Go to DONE when the counter reaches 0.
  - Request inputs are ignored while in WAIT.
- DONE (exactly one cycle):
  - A write commits to RAM on this edge.
  - A read updates `DATA` on this edge.
  - `ready` = 1 and `busy` = 0 during this cycle.
  - Next state is IDLE. A new request can be accepted on the following edge, so back-to-back throughput is one access per WAIT_STATES+2 cycles.
- Latency: from the request edge to `ready` high is WAIT_STATES+1 cycles.
- Address mapping: offset = adr - BASE_ADDR, computed in 32 bits (unsigned).
- Fault conditions:
  - offset + access_bytes > DEPTH_BYTES (this also covers adr < BASE_ADDR via wrap).
  - Halfword with offset[0] ≠ 0.
  - Word with offset[log2(DATA_W/8)-1:0] ≠ 0.
  - size = 11.
- On a fault:
  - No RAM write occurs and `DATA` holds its previous value.
  - `err` = 1 together with `ready` in DONE.
  - The full wait latency still applies.
- Endianness (big-endian case):
  - A word read forms {mem[o], mem[o+1], …}.
  - A halfword read forms {mem[o], mem[o+1]}.
  - Little-endian mode uses the reverse byte order.
- Narrow reads: the byte or halfword result is placed in the LS bits. Upper bits are the sign bit if `sign_ext` = 1, otherwise 0.
- Narrow writes: only the addressed bytes change; neighbouring bytes are untouched.
- Reset mid-operation: on the next edge, return to IDLE and clear all outputs.
  - A write not yet in DONE is never committed.
  - A write in DONE on the same edge as `rst` is not committed either, because reset has priority.
- Last valid word: offset = DEPTH_BYTES - DATA_W/8 is accepted; one byte beyond that faults.

Test Plan:
1. Defaults, WAIT_STATES=0: write word 0xDEADBEEF at 1024, then read a word at 1024.
   -> `ready` 1 cycle after each request; `DATA` = 0xDEADBEEF.
   -> Byte read at 1024 gives 0x000000DE; byte read at 1027 gives 0x000000EF.
2. Byte/halfword: write byte 0x80 at 1025 over 0x11223344, then read the word.
   -> `DATA` = 0x11803344.
   -> Halfword read at 1024 with `sign_ext`=1 gives 0x00001180.
   -> Byte read at 1025 with `sign_ext`=1 gives 0xFFFFFF80.
3. WAIT_STATES=3: read request.
   -> `busy` high for 4 cycles, `ready` on the 4th cycle after the request edge.
   -> `MEM_R_EN` toggling during WAIT has no effect.
4. Faults:
   -> Word read at 1026: `err` and `ready` pulse, `DATA` unchanged.
   -> Word write at 1532 is accepted; word write at 1536 gives `err`, and the word at 1532 is unchanged.
   -> Read at 1020 gives `err`.
5. Simultaneous `MEM_R_EN`=`MEM_W_EN`=1 at 1028 with data_in=0x55: read returns the old contents, and a follow-up read shows no write occurred.
6. Reset mid-write, WAIT_STATES=2: assert `rst` in the first WAIT cycle.
   -> Outputs go to 0 on the next edge and the target word is unchanged.
   -> A subsequent normal read works.
